// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial-pattern detector.
package seq_det_pkg;

    // Detector FSM: filling history, or holding a full PAT_W-1 bit window.
    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } seqdet_state_e;

    // Pattern loaded at reset when the parameter is left at its default.
    localparam logic [3:0] SEQDET_DEF_PATTERN = 4'b0110;

    // Legal pattern lengths.
    localparam int SEQDET_PAT_W_MIN = 2;
    localparam int SEQDET_PAT_W_MAX = 16;

    // Width of a counter that must hold 0..pat_w-1 (never less than one bit).
    function automatic int seqdet_fill_w(input int pat_w);
        int w;
        w = $clog2(pat_w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_det_shift_hist.sv
// History shift register (newest bit in the LSB) plus saturating fill counter.
// clr has priority over shift; reset has priority over both.
module seq_det_shift_hist #(
    parameter int PAT_W  = 4,
    parameter int FILL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift,
    input  logic              in_bit,
    output logic [PAT_W-2:0]  hist,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_r;
    logic [PAT_W-2:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_r;

    // With PAT_W = 2 the history is a single bit, so a shift is a plain load.
    generate
        if (PAT_W == 2) begin : g_hist_one
            assign hist_nxt_s = in_bit;
        end else begin : g_hist_multi
            assign hist_nxt_s = {hist_r[PAT_W-3:0], in_bit};
        end
    endgenerate

    // History and fill counter update: reset, clear, or shift with saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (clr) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (shift) begin
            hist_r <= hist_nxt_s;
            if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_W'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    assign hist = hist_r;
    assign fill = fill_r;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with run-time programmable
// pattern, overlap/non-overlap mode and input qualifier.
// Optional feature macro: SEQDET_MATCH_CNT_EN adds a saturating match counter
// on port match_cnt.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W         = 4,
    parameter logic [PAT_W-1:0] RESET_PATTERN = SEQDET_DEF_PATTERN,
    parameter int               MATCH_CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap_en,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    output logic             z,
    output logic             armed
`ifdef SEQDET_MATCH_CNT_EN
    ,
    output logic [MATCH_CNT_W-1:0] match_cnt
`endif
);

    localparam int FILL_W = seqdet_fill_w(PAT_W);

    // Reject out-of-range configurations at elaboration.
    generate
        if ((PAT_W < SEQDET_PAT_W_MIN) || (PAT_W > SEQDET_PAT_W_MAX)) begin : g_bad_pat_w
            $error("seq_detector_param: PAT_W out of range");
        end
        if (MATCH_CNT_W < 1) begin : g_bad_cnt_w
            $error("seq_detector_param: MATCH_CNT_W must be at least 1");
        end
    endgenerate

    logic [PAT_W-1:0]  pat_r;
    seqdet_state_e     state_r;
    seqdet_state_e     state_nxt_s;
    logic [PAT_W-2:0]  hist_s;
    logic [FILL_W-1:0] fill_s;
    logic              consume_s;
    logic              cmp_s;
    logic              match_s;
    logic              clr_s;
    logic              shift_s;
    logic              armed_s;

    // A bit is consumed only when valid and not swallowed by a pattern load.
    assign consume_s = in_valid & ~cfg_load;
    assign armed_s   = (state_r == S_ARMED);
    assign cmp_s     = ({hist_s, in_bit} == pat_r);
    assign match_s   = consume_s & armed_s & cmp_s & ~reset;

    // Non-overlapping matches and pattern loads restart the history window.
    assign clr_s   = cfg_load | (match_s & ~overlap_en);
    assign shift_s = consume_s & ~clr_s;

    seq_det_shift_hist #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_hist (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_s),
        .shift  (shift_s),
        .in_bit (in_bit),
        .hist   (hist_s),
        .fill   (fill_s)
    );

    // Pattern register: reset default, or new pattern on cfg_load.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= RESET_PATTERN;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
        end else begin
            pat_r <= pat_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: arm when the fill counter reaches PAT_W-1, drop on clear.
    always_comb begin
        state_nxt_s = state_r;
        if (clr_s) begin
            state_nxt_s = S_FILL;
        end else if (shift_s) begin
            case (state_r)
                S_FILL: begin
                    if (fill_s == FILL_W'(PAT_W - 2)) begin
                        state_nxt_s = S_ARMED;
                    end else begin
                        state_nxt_s = S_FILL;
                    end
                end
                S_ARMED: begin
                    state_nxt_s = S_ARMED;
                end
                default: begin
                    state_nxt_s = S_FILL;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign z     = match_s;
    assign armed = armed_s;

`ifdef SEQDET_MATCH_CNT_EN
    localparam logic [MATCH_CNT_W-1:0] CNT_MAX = {MATCH_CNT_W{1'b1}};

    logic [MATCH_CNT_W-1:0] match_cnt_r;

    // Saturating match counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_cnt_r <= {MATCH_CNT_W{1'b0}};
        end else if (match_s && (match_cnt_r != CNT_MAX)) begin
            match_cnt_r <= match_cnt_r + MATCH_CNT_W'(1);
        end else begin
            match_cnt_r <= match_cnt_r;
        end
    end

    assign match_cnt = match_cnt_r;
`else
    // No match counter in this build.
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PAT_W = 4, default
// pattern 0110). Counter checks are active when SEQDET_MATCH_CNT_EN is defined.
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       overlap_en;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       z;
    logic       armed;
`ifdef SEQDET_MATCH_CNT_EN
    logic [1:0] match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    seq_detector_param #(
        .PAT_W         (4),
        .RESET_PATTERN (4'b0110),
        .MATCH_CNT_W   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .overlap_en  (overlap_en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .z           (z),
        .armed       (armed)
`ifdef SEQDET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check z before the edge, armed after it.
    task automatic step(input string tag, input logic v, input logic b, input logic ov,
                        input logic ld, input logic [3:0] pat, input logic rst,
                        input logic ez, input logic ea);
        @(negedge clk);
        in_valid    = v;
        in_bit      = b;
        overlap_en  = ov;
        cfg_load    = ld;
        cfg_pattern = pat;
        reset       = rst;
        #1;
        check({tag, " z"}, {31'd0, z}, {31'd0, ez});
        @(posedge clk);
        #1;
        check({tag, " armed"}, {31'd0, armed}, {31'd0, ea});
    endtask

    // Feed n valid bits MSB-first with per-bit expected z and armed-after.
    task automatic run_stream(input string tag, input logic [15:0] bits, input logic [15:0] zx,
                              input logic [15:0] ax, input int n, input logic ov);
        for (int i = 0; i < n; i++) begin
            step($sformatf("%s b%0d", tag, i + 1), 1'b1, bits[n-1-i], ov, 1'b0, 4'b0000,
                 1'b0, zx[n-1-i], ax[n-1-i]);
        end
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] s_bits;
        logic [15:0] s_z;
        logic [15:0] s_a;
        int          exp_cnt;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        overlap_en  = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = 4'b0000;

        // Reset state
        do_reset("rst0");

        // Overlapping detection of 0110 in 0110110
        run_stream("ovl", 16'b0110110, 16'b0001001, 16'b0011111, 7, 1'b1);

        // Non-overlapping: second match needs four fresh bits
        do_reset("rst1");
        run_stream("novl", 16'b0110110, 16'b0001000, 16'b0010001, 7, 1'b0);

        // Load 1011 with a valid bit in the same cycle (bit must be discarded)
        step("load", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        run_stream("pat1011", 16'b1011011, 16'b0001001, 16'b0011111, 7, 1'b1);

        // Qualifier gaps: no z and no state change while in_valid is low
        do_reset("rst2");
        run_stream("gap pre", 16'b011, 16'b000, 16'b001, 3, 1'b1);
        s_bits = 16'b10101;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("gap idle%0d", i), 1'b0, s_bits[4-i], 1'b1, 1'b0, 4'b0000,
                 1'b0, 1'b0, 1'b1);
        end
        step("gap final", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);

        // Reset wins over a valid bit and restores the default pattern
        do_reset("rst3");
        step("rw load", 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        run_stream("rw pre", 16'b011, 16'b000, 16'b001, 3, 1'b1);
        step("rw reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        run_stream("rw post", 16'b0110, 16'b0001, 16'b0011, 4, 1'b1);

        // Five overlapping matches; counter (if present) saturates at 3
        do_reset("rst4");
`ifdef SEQDET_MATCH_CNT_EN
        check("cnt reset", {30'd0, match_cnt}, 32'd0);
`endif
        s_bits  = 16'b0110110110110110;
        s_z     = 16'b0001001001001001;
        s_a     = 16'b0011111111111111;
        exp_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step($sformatf("sat b%0d", i + 1), 1'b1, s_bits[15-i], 1'b1, 1'b0, 4'b0000,
                 1'b0, s_z[15-i], s_a[15-i]);
            if (s_z[15-i] && exp_cnt < 3) begin
                exp_cnt++;
            end
`ifdef SEQDET_MATCH_CNT_EN
            check($sformatf("cnt b%0d", i + 1), {30'd0, match_cnt}, exp_cnt);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
